// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier. It has valid/ready handshakes on the operand side and on the product side.
// Defining MULT_SIGNED_EN adds the signed_mode port, which selects two's-complement operands.
module seq_shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
   input  logic               signed_mode,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned      PW        = 2 * WIDTH;
   localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [PW-1:0]    acc;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] a_load_c;
   logic [WIDTH-1:0] b_load_c;
   logic [WIDTH:0]   sum_c;
   logic [PW-1:0]    acc_next_c;
   logic [PW-1:0]    result_c;

`ifdef MULT_SIGNED_EN
   logic neg_reg;
   logic neg_load_c;

   // Signed operands are reduced to magnitudes. The sign is restored when p is loaded.
   always_comb begin
      a_load_c   = a;
      b_load_c   = b;
      neg_load_c = 1'b0;
      if (signed_mode) begin
         if (a[WIDTH-1]) a_load_c = ~a + WIDTH'(1);
         if (b[WIDTH-1]) b_load_c = ~b + WIDTH'(1);
         neg_load_c = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   assign result_c = neg_reg ? (~acc_next_c + PW'(1)) : acc_next_c;
`else
   assign a_load_c = a;
   assign b_load_c = b;
   assign result_c = acc_next_c;
`endif

   // One iteration: conditionally add a_reg to the upper half, then shift {carry, acc} right.
   always_comb begin
      sum_c      = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (b_reg[0] ? a_reg : WIDTH'(0))};
      acc_next_c = PW'({sum_c, acc[WIDTH-1:0]} >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         p         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         count     <= '0;
`ifdef MULT_SIGNED_EN
         neg_reg   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a_load_c;
                  b_reg    <= b_load_c;
                  acc      <= '0;
                  count    <= '0;
`ifdef MULT_SIGNED_EN
                  neg_reg  <= neg_load_c;
`endif
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next_c;
               b_reg <= b_reg >> 1;
               count <= count + CNT_W'(1);
               if (count == LAST_ITER) begin
                  p         <= result_c;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // A pending operand waits until the next IDLE cycle.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier. It checks a WIDTH=8 instance and a WIDTH=16 instance against an arithmetic model.
// The signed cases are active only when MULT_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

   localparam int unsigned W8  = 8;
   localparam int unsigned W16 = 16;

   logic        clk;
   logic        rst_n;
   logic        iv8, ir8, ov8, or8, sm8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv16, ir16, ov16, or16, sm16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_shift_add_multiplier #(.WIDTH(W8)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv8),
      .in_ready   (ir8),
      .a          (a8),
      .b          (b8),
`ifdef MULT_SIGNED_EN
      .signed_mode(sm8),
`endif
      .out_valid  (ov8),
      .out_ready  (or8),
      .p          (p8)
   );

   seq_shift_add_multiplier #(.WIDTH(W16)) u_dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv16),
      .in_ready   (ir16),
      .a          (a16),
      .b          (b16),
`ifdef MULT_SIGNED_EN
      .signed_mode(sm16),
`endif
      .out_valid  (ov16),
      .out_ready  (or16),
      .p          (p16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference product: operands are read as n-bit integers (signed if sm), product reduced mod 2^(2n).
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input bit sm, input int n);
      longint sx, sy, prod, modulus;
      sx = longint'(x);
      sy = longint'(y);
      modulus = longint'(1) << (2 * n);
      if (sm && x[n-1]) sx = sx - (longint'(1) << n);
      if (sm && y[n-1]) sy = sy - (longint'(1) << n);
      prod = sx * sy;
      if (prod < 0) prod = prod + modulus;
      return 64'(prod % modulus);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- WIDTH=8 helpers ----------------
   task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic sm);
      int guard = 0;
      while (!ir8 && guard < 100) begin step(); guard++; end
      check("ready8", 64'(ir8), 64'(1));
      a8 = x; b8 = y; sm8 = sm; iv8 = 1'b1;
      step();
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
   endtask

   task automatic wait8(output int lat);
      lat = 0;
      while (!ov8 && lat < 64) begin step(); lat++; end
   endtask

   task automatic finish8();
      or8 = 1'b1;
      step();
      or8 = 1'b0;
      check("rel8_valid", 64'(ov8), 64'(0));
      check("rel8_ready", 64'(ir8), 64'(1));
   endtask

   task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic sm);
      int lat;
      start8(x, y, sm);
      wait8(lat);
      check({tag, "_lat"}, 64'(lat), 64'(W8));
      check({tag, "_p"}, 64'(p8), ref_mul(32'(x), 32'(y), sm, 8));
      finish8();
   endtask

   // ---------------- WIDTH=16 helpers ----------------
   task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y, input logic sm);
      int lat;
      int guard = 0;
      while (!ir16 && guard < 100) begin step(); guard++; end
      check({tag, "_ready"}, 64'(ir16), 64'(1));
      a16 = x; b16 = y; sm16 = sm; iv16 = 1'b1;
      step();
      iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
      lat = 0;
      while (!ov16 && lat < 64) begin step(); lat++; end
      check({tag, "_lat"}, 64'(lat), 64'(W16));
      check({tag, "_p"}, 64'(p16), ref_mul(32'(x), 32'(y), sm, 16));
      or16 = 1'b1;
      step();
      or16 = 1'b0;
      check({tag, "_rel"}, 64'(ov16), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_p;
      logic [15:0] expq[$];
      int          acc_t[$];
      int          lat, cyc, got, nacc;
      bit          took;
      logic [15:0] rx, ry;
      logic        rsm;

      rst_n = 1'b0;
      iv8 = 0; or8 = 0; sm8 = 0; a8 = '0; b8 = '0;
      iv16 = 0; or16 = 0; sm16 = 0; a16 = '0; b16 = '0;
      #23;
      check("rst_ready8", 64'(ir8), 64'(1));
      check("rst_valid8", 64'(ov8), 64'(0));
      check("rst_p8", 64'(p8), 64'(0));
      check("rst_ready16", 64'(ir16), 64'(1));
      check("rst_p16", 64'(p16), 64'(0));
      rst_n = 1'b1;
      step();

      // Corner operands
      op8("ffxff", 8'hFF, 8'hFF, 1'b0);
      check("ffxff_const", 64'(p8), 64'h0000_FE01);
      op8("zero", 8'h00, 8'h5A, 1'b0);
      op8("onexone", 8'h01, 8'h01, 1'b0);

      // Back-pressure: DONE is held, and a pulsed operand is ignored
      start8(8'h12, 8'h34, 1'b0);
      wait8(lat);
      check("bp_lat", 64'(lat), 64'(W8));
      exp_p = 16'(ref_mul(32'h12, 32'h34, 1'b0, 8));
      for (int i = 0; i < 5; i++) begin
         iv8 = (i == 2); a8 = 8'h99; b8 = 8'h77;
         step();
         check("bp_valid", 64'(ov8), 64'(1));
         check("bp_p", 64'(p8), 64'(exp_p));
         check("bp_ready", 64'(ir8), 64'(0));
      end
      iv8 = 1'b0;
      finish8();
      check("bp_p_kept", 64'(p8), 64'(exp_p));

      // Reset in the middle of an operation
      start8(8'h55, 8'h66, 1'b0);
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(ov8), 64'(0));
      check("mid_rst_p", 64'(p8), 64'(0));
      check("mid_rst_ready", 64'(ir8), 64'(1));
      step();
      rst_n = 1'b1;
      repeat (10) step();
      check("mid_rst_noemit", 64'(ov8), 64'(0));
      op8("post_rst", 8'd3, 8'd7, 1'b0);
      check("post_rst_21", 64'(p8), 64'd21);

      // Back-to-back: in_valid is held high and out_ready is always 1
      or8 = 1'b1; sm8 = 1'b0; iv8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
      cyc = 0; got = 0; nacc = 0;
      while (got < 2 && cyc < 100) begin
         took = iv8 && ir8;
         step();
         cyc++;
         if (took) begin
            acc_t.push_back(cyc);
            expq.push_back(16'(ref_mul(32'(a8), 32'(b8), 1'b0, 8)));
            nacc++;
            if (nacc == 1) begin a8 = 8'd4; b8 = 8'd5; end
            else iv8 = 1'b0;
         end
         if (ov8) begin
            if (expq.size() > 0) check("b2b_p", 64'(p8), 64'(expq.pop_front()));
            else check("b2b_extra", 64'(ov8), 64'(0));
            got++;
         end
      end
      iv8 = 1'b0; or8 = 1'b0;
      check("b2b_count", 64'(got), 64'(2));
      check("b2b_accepts", 64'(acc_t.size()), 64'(2));
      if (acc_t.size() == 2) check("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'(W8 + 2));
      step();

`ifdef MULT_SIGNED_EN
      op8("s_80x80", 8'h80, 8'h80, 1'b1);
      check("s_80x80_const", 64'(p8), 64'h4000);
      op8("s_fdx05", 8'hFD, 8'h05, 1'b1);
      check("s_fdx05_const", 64'(p8), 64'hFFF1);
      op8("u_fdx05", 8'hFD, 8'h05, 1'b0);
      check("u_fdx05_const", 64'(p8), 64'h04F1);
`endif

      // WIDTH=16, first the all-ones corner and then random operands
      op16("w16_max", 16'hFFFF, 16'hFFFF, 1'b0);
      check("w16_max_const", 64'(p16), 64'hFFFE_0001);
      for (int i = 0; i < 1000; i++) begin
         rx = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
         ry = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
`ifdef MULT_SIGNED_EN
         rsm = 1'($urandom);
`else
         rsm = 1'b0;
`endif
         op16("rnd16", rx, ry, rsm);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
